// File: rtl/cp0.sv
// cp0: coprocessor-0 exception/interrupt control with SR, Cause, EPC and PRId registers
module cp0 #(
  parameter logic [31:0] PRID = 32'h0000_2019
) (
  input  logic        CP0_i_Clk,
  input  logic        CP0_i_Rst_n,
  input  logic        CP0_i_Valid,
  input  logic [4:0]  CP0_i_ExcCode,
  input  logic [31:0] CP0_i_PC,
  input  logic        CP0_i_BD,
  input  logic [5:0]  CP0_i_HWInt,
  input  logic        CP0_i_WE,
  input  logic [4:0]  CP0_i_Addr,
  input  logic [31:0] CP0_i_WData,
  input  logic        CP0_i_EXLClr,
  output logic [31:0] CP0_o_RData,
  output logic [31:0] CP0_o_EPC,
  output logic        CP0_o_IntReq
);
  logic [5:0]  im, ip;
  logic        exl, ie, bd;
  logic [4:0]  exc_code;
  logic [31:0] epc, sr, cause, pc_al;
  logic        int_pend, exc_pend, int_req, wr_sr, wr_epc;

  assign int_pend = ie & |(CP0_i_HWInt & im);
  assign exc_pend = CP0_i_Valid & (CP0_i_ExcCode != 5'd0);
  assign int_req  = ~exl & ~CP0_i_EXLClr & (int_pend | exc_pend);
  assign wr_sr    = CP0_i_WE & (CP0_i_Addr == 5'd12);
  assign wr_epc   = CP0_i_WE & (CP0_i_Addr == 5'd14);
  assign pc_al    = {CP0_i_PC[31:2], 2'b00};
  assign sr       = {16'b0, im, 8'b0, exl, ie};
  assign cause    = {bd, 15'b0, ip, 3'b0, exc_code, 2'b00};

  assign CP0_o_IntReq = int_req;
  assign CP0_o_EPC    = epc;

  // mfc0 read mux shows pre-edge register values
  always_comb begin
    CP0_o_RData = (CP0_i_Addr == 5'd12) ? sr :
                  (CP0_i_Addr == 5'd13) ? cause :
                  (CP0_i_Addr == 5'd14) ? epc :
                  (CP0_i_Addr == 5'd15) ? PRID : 32'd0;
  end

  // IP mirrors the hardware interrupt lines every cycle, regardless of EXL
  always_ff @(posedge CP0_i_Clk or negedge CP0_i_Rst_n) begin
    if (!CP0_i_Rst_n) ip <= 6'd0;
    else              ip <= CP0_i_HWInt;
  end

  // exception entry beats mtc0; eret clears EXL even when SR is written the same cycle
  always_ff @(posedge CP0_i_Clk or negedge CP0_i_Rst_n) begin
    if (!CP0_i_Rst_n) begin
      im       <= 6'd0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      exc_code <= 5'd0;
      epc      <= 32'd0;
    end else if (int_req) begin
      exl      <= 1'b1;
      bd       <= CP0_i_BD;
      exc_code <= int_pend ? 5'd0 : CP0_i_ExcCode;
      epc      <= CP0_i_BD ? pc_al - 32'd4 : pc_al;
    end else begin
      if (wr_sr) begin
        im <= CP0_i_WData[15:10];
        ie <= CP0_i_WData[0];
      end
      exl <= CP0_i_EXLClr ? 1'b0 : wr_sr ? CP0_i_WData[1] : exl;
      if (wr_epc) epc <= CP0_i_WData;
    end
  end
endmodule

// File: tb/tb_cp0.sv
// tb_cp0: directed stimulus with a word-level CP0 model checked every cycle
module tb_cp0;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [4:0]  exc = 5'd0;
  logic [31:0] pc = 32'd0;
  logic        bd = 1'b0;
  logic [5:0]  hwint = 6'd0;
  logic        we = 1'b0;
  logic [4:0]  addr = 5'd0;
  logic [31:0] wdata = 32'd0;
  logic        exlclr = 1'b0;
  logic [31:0] rdata, epc;
  logic        intreq;
  int          checks = 0;
  int          errors = 0;

  logic [31:0] m_sr, m_cause, m_epc;

  cp0 dut (
    .CP0_i_Clk(clk), .CP0_i_Rst_n(rst_n), .CP0_i_Valid(valid), .CP0_i_ExcCode(exc),
    .CP0_i_PC(pc), .CP0_i_BD(bd), .CP0_i_HWInt(hwint), .CP0_i_WE(we), .CP0_i_Addr(addr),
    .CP0_i_WData(wdata), .CP0_i_EXLClr(exlclr), .CP0_o_RData(rdata), .CP0_o_EPC(epc),
    .CP0_o_IntReq(intreq)
  );

  always #5 clk = ~clk;

  function automatic logic m_intpend();
    return m_sr[0] && ((hwint & m_sr[15:10]) != 6'd0);
  endfunction

  function automatic logic m_intreq();
    return !m_sr[1] && !exlclr && (m_intpend() || (valid && exc != 5'd0));
  endfunction

  function automatic logic [31:0] m_rdata();
    case (addr)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_2019;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sr    <= 32'd0;
      m_cause <= 32'd0;
      m_epc   <= 32'd0;
    end else if (m_intreq()) begin
      m_sr    <= m_sr | 32'd2;
      m_cause <= {bd, 15'b0, hwint, 3'b0, m_intpend() ? 5'd0 : exc, 2'b00};
      m_epc   <= (pc & ~32'd3) - (bd ? 32'd4 : 32'd0);
    end else begin
      m_sr    <= ((we && addr == 5'd12) ? (wdata & 32'h0000_FC03) : m_sr) & ~(exlclr ? 32'd2 : 32'd0);
      m_cause <= {m_cause[31:16], hwint, m_cause[9:0]};
      if (we && addr == 5'd14) m_epc <= wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_intreq", {31'd0, intreq}, {31'd0, m_intreq()});
    chk("model_rdata", rdata, m_rdata());
    chk("model_epc", epc, m_epc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, rdata, exp);
  endtask

  task automatic idle();
    valid = 1'b0; exc = 5'd0; bd = 1'b0; we = 1'b0; exlclr = 1'b0;
  endtask

  initial begin
    tick(); tick();
    rd("rst_sr", 5'd12, 32'd0);
    rd("rst_cause", 5'd13, 32'd0);
    rd("rst_epc", 5'd14, 32'd0);
    rd("rst_prid", 5'd15, 32'h0000_2019);
    chk("rst_intreq", {31'd0, intreq}, 32'd0);
    rst_n = 1'b1;
    tick();
    valid = 1'b1; exc = 5'd12; pc = 32'h0000_3010;
    #1 chk("exc_intreq", {31'd0, intreq}, 32'd1);
    tick(); idle();
    rd("exc_sr", 5'd12, 32'h0000_0002);
    rd("exc_cause", 5'd13, 32'h0000_0030);
    rd("exc_epc", 5'd14, 32'h0000_3010);
    exlclr = 1'b1; tick(); idle();
    valid = 1'b1; exc = 5'd4; pc = 32'h0000_3024; bd = 1'b1;
    tick(); idle();
    rd("bd_cause", 5'd13, 32'h8000_0010);
    chk("bd_epc", epc, 32'h0000_3020);
    exlclr = 1'b1; tick(); idle();
    we = 1'b1; addr = 5'd12; wdata = 32'h0000_0401; tick(); idle();
    rd("mtc0_sr", 5'd12, 32'h0000_0401);
    hwint = 6'b000001; valid = 1'b1; exc = 5'd10; pc = 32'h0000_3100;
    #1 chk("int_intreq", {31'd0, intreq}, 32'd1);
    tick(); idle();
    rd("int_cause", 5'd13, 32'h0000_0400);
    rd("int_sr", 5'd12, 32'h0000_0403);
    valid = 1'b1; exc = 5'd5; pc = 32'h0000_3200;
    #1 chk("nested_intreq", {31'd0, intreq}, 32'd0);
    tick(); idle();
    chk("nested_epc", epc, 32'h0000_3100);
    exlclr = 1'b1;
    #1 chk("eret_intreq", {31'd0, intreq}, 32'd0);
    tick(); idle();
    rd("eret_sr", 5'd12, 32'h0000_0401);
    chk("post_eret_intreq", {31'd0, intreq}, 32'd1);
    tick();
    hwint = 6'd0; exlclr = 1'b1; tick(); idle();
    we = 1'b1; addr = 5'd14; wdata = 32'h0000_4000; valid = 1'b1; exc = 5'd12; pc = 32'h0000_3000;
    tick(); idle();
    chk("collide_epc", epc, 32'h0000_3000);
    we = 1'b1; addr = 5'd12; wdata = 32'h0000_0C03; exlclr = 1'b1;
    tick(); idle();
    rd("eret_mtc0_sr", 5'd12, 32'h0000_0C01);
    rd("unused_addr", 5'd3, 32'd0);
    we = 1'b1; addr = 5'd14; wdata = 32'h0000_5555;
    #1 chk("no_forward", rdata, 32'h0000_3000);
    tick(); idle();
    rd("mtc0_epc", 5'd14, 32'h0000_5555);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_epc", epc, 32'd0);
    tick(); rst_n = 1'b1;
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 exception/interrupt control stage, sitting directly downstream of the exception checker at the M/W boundary. It consumes the merged exception code and M-stage PC, arbitrates against external hardware interrupts, and raises a one-cycle flush/redirect request. It holds the architectural SR, Cause, EPC and PRId registers, serves mfc0/mtc0, and clears EXL on eret.

## Interface
- PRID, 32'h0000_2019, constant value returned for register 15
- CP0_i_Clk  in  1  rising-edge clock
- CP0_i_Rst_n  in  1  asynchronous active-low reset
- CP0_i_Valid  in  1  M-stage slot holds a real instruction (0 = bubble)
- CP0_i_ExcCode  in  5  merged exception code from the exception checker; 0 = none (AdEL 4, AdES 5, RI 10, Ov 12)
- CP0_i_PC  in  32  PC of the M-stage instruction
- CP0_i_BD  in  1  M-stage instruction is in a branch delay slot
- CP0_i_HWInt  in  6  external interrupt lines, level-sensitive
- CP0_i_WE  in  1  mtc0 write enable
- CP0_i_Addr  in  5  CP0 register number for mfc0/mtc0
- CP0_i_WData  in  32  mtc0 write data
- CP0_i_EXLClr  in  1  eret in M stage
- CP0_o_RData  out  32  mfc0 read data (combinational)
- CP0_o_EPC  out  32  current EPC register
- CP0_o_IntReq  out  1  take exception/interrupt this cycle (combinational)

## Operation
- Registers: SR(12) = {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]}; Cause(13) = {BD[31], 15'b0, IP[15:10], 3'b0, ExcCode[6:2], 2'b0}; EPC(14) full 32 bits; PRId(15) = PRID. Unused bits read 0.
- Reset (async, Rst_n=0): SR=0, Cause=0, EPC=0; outputs IntReq=0, RData reflects reset registers.
- IP[15:10] <= CP0_i_HWInt every cycle (independent of everything else).
- IntPend = IE & |(HWInt & IM); ExcPend = Valid & (ExcCode != 0).
- IntReq = !EXL & !EXLClr & (IntPend | ExcPend). Interrupts gate on !EXL only, not on Valid.
- Priority: interrupt over exception. On IntReq at the edge: EXL<=1; Cause.ExcCode <= IntPend ? 0 : CP0_i_ExcCode; Cause.BD <= BD; EPC <= BD ? {PC[31:2],2'b00}-4 : {PC[31:2],2'b00}.
- Interrupt taken while M holds a bubble: EPC/BD still latched from CP0_i_PC/CP0_i_BD; upstream supplies the next-to-execute PC in the bubble slot.
- mtc0 (WE=1, IntReq=0): Addr 12 writes IM, EXL, IE from WData; Addr 14 writes EPC; Addr 13, 15 and others ignored.
- mtc0 with IntReq=1 in the same cycle: write discarded; exception update wins.
- eret (EXLClr=1): EXL<=0 at the edge; IntReq forced 0 that cycle. If WE to SR coincides, EXLClr wins for EXL bit, other SR fields take WData.
- mfc0: RData = register selected by Addr (12/13/14/15), else 0; shows pre-edge values (no write-through forwarding).

## Timing
- IntReq combinational from current state plus inputs; all register updates take effect at the following rising edge.
- Exception-to-EXL set: 1 cycle. mtc0-to-mfc0 visibility: 1 cycle. eret-to-EXL clear: 1 cycle; new interrupt can be taken the cycle after eret.
- While EXL=1, nested exceptions/interrupts produce no IntReq and do not modify Cause/EPC; IP keeps tracking HWInt.
- Reset deasserting mid-operation: first edge after release behaves as from reset state; asserting reset mid-cycle clears registers immediately.

## Test plan
- Reset: Rst_n=0 -> RData for Addr 12/13/14 = 0, Addr 15 = 32'h0000_2019, IntReq=0.
- Exception: Valid=1, ExcCode=12, PC=32'h0000_3010, BD=0 -> IntReq=1; next cycle SR.EXL=1, Cause=32'h0000_0030, EPC=32'h0000_3010.
- Delay slot: ExcCode=4, PC=32'h0000_3024, BD=1 -> next cycle Cause=32'h8000_0010, EPC=32'h0000_3020.
- Interrupt priority: mtc0 SR=32'h0000_0401, then HWInt=6'b000001 with ExcCode=10 -> IntReq=1; Cause.ExcCode=0, IP=6'b000001; while EXL=1 further ExcCode=5 -> IntReq=0, EPC unchanged.
- eret: EXL=1, EXLClr=1 with HWInt pending -> IntReq=0 that cycle, EXL=0 next, IntReq=1 the cycle after.
- Collision: WE=1, Addr=14, WData=32'h0000_4000 same cycle as ExcCode=12, PC=32'h0000_3000 -> EPC=32'h0000_3000.
